// File: rtl/edf_ic_pkg.sv
// Shared types and helpers for the EDF interrupt controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package edf_ic_pkg;

  // Claim handshake states: waiting for a winner, requesting the core, in service.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } claim_state_e;

  // ID width for a given number of sources; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned nr_irqs);
    return (nr_irqs > 2) ? $clog2(nr_irqs) : 1;
  endfunction

endpackage

// File: rtl/edf_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Latency: count updates one cycle after clr/en are sampled.
// Backpressure: none; holds at all-ones once saturated.
module edf_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] count,
  output logic             at_max
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] one;

  assign one    = {{(Width-1){1'b0}}, 1'b1};
  assign at_max = &count_q;
  assign count  = count_q;

  // Clear has priority over counting; stop at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && !at_max) begin
      count_q <= count_q + one;
    end
  end

endmodule

// File: rtl/edf_irq_claim.sv
// Claim/complete handshake between the EDF priority queue and the core.
// Latency: every output is registered or decoded from state; input effects appear next cycle.
// Backpressure: queue winners are held off while one interrupt is in service (no nesting).
module edf_irq_claim
  import edf_ic_pkg::*;
#(
  parameter  int unsigned NrParIrqs = 2,
  parameter  int unsigned CntWidth  = 16,
  localparam int unsigned IdWidth   = id_width(NrParIrqs)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                irq_valid_i,
  input  logic [IdWidth-1:0]  irq_id_i,
  output logic                pop_o,
  output logic [IdWidth-1:0]  pop_id_o,
  output logic                irq_o,
  output logic [IdWidth-1:0]  irq_id_o,
  input  logic                irq_ack_i,
  output logic                active_o,
  input  logic                complete_i,
  input  logic [IdWidth-1:0]  complete_id_i,
  output logic                err_o,
  output logic [CntWidth-1:0] service_cycles_o
);

  claim_state_e        state_q, state_d;
  logic [IdWidth-1:0]  id_q, id_d;
  logic                pop_q, pop_d;
  logic [IdWidth-1:0]  pop_id_q, pop_id_d;
  logic                err_q, err_d;
  logic [CntWidth-1:0] svc_q, svc_d;

  logic                cnt_clr;
  logic                cnt_en;
  logic [CntWidth-1:0] cnt;
  logic                cnt_max;
  logic [CntWidth-1:0] cnt_one;
  logic                complete_ok;

  assign cnt_one = {{(CntWidth-1){1'b0}}, 1'b1};

  // A completion is legal only while in service and only for the claimed ID.
  assign complete_ok = complete_i && (state_q == ACTIVE) && (complete_id_i == id_q);

  // Service-cycle counter: cleared on claim, runs through every ACTIVE cycle.
  edf_sat_counter #(
    .Width (CntWidth)
  ) u_svc_cnt (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .count  (cnt),
    .at_max (cnt_max)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-register decode for the claim handshake.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    pop_d    = 1'b0;
    pop_id_d = pop_id_q;
    svc_d    = svc_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    err_d    = complete_i && !complete_ok;

    unique case (state_q)
      IDLE: begin
        if (irq_valid_i) begin
          id_d    = irq_id_i;
          state_d = REQ;
        end
      end

      REQ: begin
        // Ack beats a same-cycle winner change: the core claimed what it saw.
        if (irq_ack_i) begin
          state_d  = ACTIVE;
          pop_d    = 1'b1;
          pop_id_d = id_q;
          cnt_clr  = 1'b1;
        end else if (!irq_valid_i) begin
          state_d = IDLE;
        end else if (irq_id_i != id_q) begin
          id_d = irq_id_i;
        end
      end

      ACTIVE: begin
        cnt_en = 1'b1;
        // Capture the count including the current ACTIVE cycle, saturated.
        if (complete_ok) begin
          svc_d   = cnt_max ? cnt : (cnt + cnt_one);
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers: latched ID, pop strobe, error strobe, last service time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q     <= '0;
      pop_q    <= 1'b0;
      pop_id_q <= '0;
      err_q    <= 1'b0;
      svc_q    <= '0;
    end else begin
      id_q     <= id_d;
      pop_q    <= pop_d;
      pop_id_q <= pop_id_d;
      err_q    <= err_d;
      svc_q    <= svc_d;
    end
  end

  assign irq_o            = (state_q == REQ);
  assign active_o         = (state_q == ACTIVE);
  assign irq_id_o         = id_q;
  assign pop_o            = pop_q;
  assign pop_id_o         = pop_id_q;
  assign err_o            = err_q;
  assign service_cycles_o = svc_q;

endmodule
